// File: rtl/uart_cmd_sequencer.sv
// ============================================================================
// Module      : uart_cmd_sequencer
// Description : Frames UART command bytes into I2C instructions and commits
//               them to the instruction queue with one aligned write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_sequencer #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffers_full,
  output logic [7:0]  addr_pointer,
  output logic [7:0]  mode,
  output logic [15:0] wr_data,
  output logic        wr_addrbuffer,
  output logic        wr_opbuffer,
  output logic        wr_databuffer1,
  output logic        wr_databuffer2,
  output logic        initiate,
  output logic        cmd_error,
  output logic        rx_dropped,
  output logic        busy
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MODE    = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CHECK   = 3'd5,
    S_COMMIT  = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [7:0]         r_csum;
  logic [1:0]         r_mode_s;
  logic [7:0]         r_addr_s;
  logic [7:0]         r_dlo;
  logic [7:0]         r_dhi;
  logic [7:0]         r_addr;
  logic [7:0]         r_mode;
  logic [15:0]        r_wdata;
  logic               r_err;
  logic               r_drop;

  logic w_in_frame;
  logic w_expired;
  logic w_commit;

  assign w_in_frame = (r_state == S_MODE) || (r_state == S_ADDR) ||
                      (r_state == S_DATA_LO) || (r_state == S_DATA_HI) ||
                      (r_state == S_CHECK);
  assign w_expired  = (r_cnt == c_TIMEOUT);
  assign w_commit   = (r_state == S_COMMIT) && !buffers_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_csum   <= 8'h00;
      r_mode_s <= 2'b00;
      r_addr_s <= 8'h00;
      r_dlo    <= 8'h00;
      r_dhi    <= 8'h00;
      r_addr   <= 8'h00;
      r_mode   <= 8'h00;
      r_wdata  <= 16'h0000;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;

      // Any accepted byte restarts the inter-byte window; counter saturates.
      if (!w_in_frame || rx_valid) begin
        r_cnt <= '0;
      end else if (!w_expired) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_in_frame && !rx_valid && w_expired) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) begin
              r_state <= S_MODE;
              r_csum  <= 8'h00;
              r_dlo   <= 8'h00;
              r_dhi   <= 8'h00;
            end
          end
          S_MODE: begin
            if (rx_valid) begin
              if (rx_data[7:2] == 6'd0) begin
                r_mode_s <= rx_data[1:0];
                r_csum   <= r_csum ^ rx_data;
                r_state  <= S_ADDR;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          S_ADDR: begin
            if (rx_valid) begin
              r_addr_s <= rx_data;
              r_csum   <= r_csum ^ rx_data;
              r_state  <= r_mode_s[1] ? S_DATA_LO : S_CHECK;
            end
          end
          S_DATA_LO: begin
            if (rx_valid) begin
              r_dlo   <= rx_data;
              r_csum  <= r_csum ^ rx_data;
              r_state <= r_mode_s[0] ? S_DATA_HI : S_CHECK;
            end
          end
          S_DATA_HI: begin
            if (rx_valid) begin
              r_dhi   <= rx_data;
              r_csum  <= r_csum ^ rx_data;
              r_state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (rx_valid) begin
              if (rx_data == r_csum) begin
                // Publish payload now so it is stable when the strobes fire.
                r_addr  <= r_addr_s;
                r_mode  <= {6'd0, r_mode_s};
                r_wdata <= {r_dhi, r_dlo};
                r_state <= S_COMMIT;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          S_COMMIT: begin
            if (!buffers_full) begin
              r_state <= S_IDLE;
            end else if (rx_valid) begin
              r_drop <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign addr_pointer   = r_addr;
  assign mode           = r_mode;
  assign wr_data        = r_wdata;
  assign wr_addrbuffer  = w_commit;
  assign wr_opbuffer    = w_commit;
  assign wr_databuffer1 = w_commit;
  assign wr_databuffer2 = w_commit;
  assign initiate       = w_commit;
  assign cmd_error      = r_err;
  assign rx_dropped     = r_drop;
  assign busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
// ============================================================================
// Module      : tb_uart_cmd_sequencer
// Description : Directed self-checking bench for uart_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        buffers_full;
  logic [7:0]  addr_pointer;
  logic [7:0]  mode;
  logic [15:0] wr_data;
  logic        wr_addrbuffer;
  logic        wr_opbuffer;
  logic        wr_databuffer1;
  logic        wr_databuffer2;
  logic        initiate;
  logic        cmd_error;
  logic        rx_dropped;
  logic        busy;

  int tests;
  int fails;
  int strobe_count;

  uart_cmd_sequencer #(
    .HEADER  (8'hA5),
    .TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .buffers_full   (buffers_full),
    .addr_pointer   (addr_pointer),
    .mode           (mode),
    .wr_data        (wr_data),
    .wr_addrbuffer  (wr_addrbuffer),
    .wr_opbuffer    (wr_opbuffer),
    .wr_databuffer1 (wr_databuffer1),
    .wr_databuffer2 (wr_databuffer2),
    .initiate       (initiate),
    .cmd_error      (cmd_error),
    .rx_dropped     (rx_dropped),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] w_strobes;
  assign w_strobes = {wr_addrbuffer, wr_opbuffer, wr_databuffer1, wr_databuffer2, initiate};

  always @(posedge clk or negedge reset) begin
    if (!reset) strobe_count <= 0;
    else if (initiate) strobe_count <= strobe_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, byte sampled in between.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, {27'd0, w_strobes}, 32'h0);
    check({tag, "_err"}, {31'd0, cmd_error}, 32'h0);
    check({tag, "_drop"}, {31'd0, rx_dropped}, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'h0);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    buffers_full = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_addr", {24'd0, addr_pointer}, 32'h0);
    check("rst_mode", {24'd0, mode}, 32'h0);
    check("rst_wdata", {16'd0, wr_data}, 32'h0);
    check_idle_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Read-1 frame: A5,01,00,01
    send(8'hA5); send(8'h01); send(8'h00);
    check("rd_busy", {31'd0, busy}, 32'h1);
    send(8'h01);
    check("rd_strobes", {27'd0, w_strobes}, 32'h1F);
    check("rd_addr", {24'd0, addr_pointer}, 32'h00);
    check("rd_mode", {24'd0, mode}, 32'h01);
    check("rd_wdata", {16'd0, wr_data}, 32'h0000);
    @(negedge clk);
    check_idle_outputs("rd_after");
    check("rd_count", strobe_count, 32'd1);

    // Write-2 frame with wrong checksum 68 (correct XOR is 64)
    send(8'hA5); send(8'h03); send(8'h01); send(8'hAB); send(8'hCD); send(8'h68);
    check("w2bad_err", {31'd0, cmd_error}, 32'h1);
    check("w2bad_strobes", {27'd0, w_strobes}, 32'h0);
    @(negedge clk);
    check("w2bad_err_clr", {31'd0, cmd_error}, 32'h0);

    // Write-2 frame: A5,03,01,AB,CD,64
    send(8'hA5); send(8'h03); send(8'h01); send(8'hAB); send(8'hCD); send(8'h64);
    check("w2_strobes", {27'd0, w_strobes}, 32'h1F);
    check("w2_addr", {24'd0, addr_pointer}, 32'h01);
    check("w2_mode", {24'd0, mode}, 32'h03);
    check("w2_wdata", {16'd0, wr_data}, 32'hCDAB);
    @(negedge clk);
    check("w2_strobes_off", {27'd0, w_strobes}, 32'h0);

    // Back-to-back bad checksum frame in first IDLE cycle: A5,02,03,5A,00
    send(8'hA5); send(8'h02); send(8'h03); send(8'h5A); send(8'h00);
    check("bad_err", {31'd0, cmd_error}, 32'h1);
    check("bad_strobes", {27'd0, w_strobes}, 32'h0);
    check("bad_busy", {31'd0, busy}, 32'h0);
    check("bad_addr_hold", {24'd0, addr_pointer}, 32'h01);
    check("bad_wdata_hold", {16'd0, wr_data}, 32'hCDAB);
    @(negedge clk);
    check("bad_err_clr", {31'd0, cmd_error}, 32'h0);

    // Illegal mode, then trailing bytes ignored
    send(8'hA5); send(8'h07);
    check("ill_err", {31'd0, cmd_error}, 32'h1);
    check("ill_busy", {31'd0, busy}, 32'h0);
    send(8'h01); send(8'h00); send(8'h01);
    repeat (2) @(negedge clk);
    check_idle_outputs("ill_after");
    check("ill_count", strobe_count, 32'd2);

    // Commit stall with a dropped byte
    buffers_full = 1'b1;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    check("stall_strobes", {27'd0, w_strobes}, 32'h0);
    check("stall_busy", {31'd0, busy}, 32'h1);
    repeat (4) @(negedge clk);
    send(8'h55);
    check("stall_drop", {31'd0, rx_dropped}, 32'h1);
    @(negedge clk);
    check("stall_drop_clr", {31'd0, rx_dropped}, 32'h0);
    repeat (13) @(negedge clk);
    check("stall_hold_strobes", {27'd0, w_strobes}, 32'h0);
    check("stall_addr", {24'd0, addr_pointer}, 32'h00);
    check("stall_mode", {24'd0, mode}, 32'h01);
    check("stall_wdata", {16'd0, wr_data}, 32'h0000);
    buffers_full = 1'b0;
    #1;
    check("stall_release", {27'd0, w_strobes}, 32'h1F);
    @(negedge clk);
    check_idle_outputs("stall_after");
    check("stall_count", strobe_count, 32'd3);

    // Timeout: counter reaches 8 after 8 idle cycles, error on the next edge
    send(8'hA5); send(8'h02);
    repeat (8) @(negedge clk);
    check("to_busy_pre", {31'd0, busy}, 32'h1);
    check("to_err_pre", {31'd0, cmd_error}, 32'h0);
    @(negedge clk);
    check("to_err", {31'd0, cmd_error}, 32'h1);
    check("to_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);

    // Byte arriving in the expiry cycle wins
    send(8'hA5); send(8'h02);
    repeat (8) @(negedge clk);
    send(8'h03);
    check("win_err", {31'd0, cmd_error}, 32'h0);
    check("win_busy", {31'd0, busy}, 32'h1);
    send(8'h5A); send(8'h5B);
    check("win_strobes", {27'd0, w_strobes}, 32'h1F);
    check("win_addr", {24'd0, addr_pointer}, 32'h03);
    check("win_mode", {24'd0, mode}, 32'h02);
    check("win_wdata", {16'd0, wr_data}, 32'h005A);
    @(negedge clk);

    // Reset mid-frame
    send(8'hA5); send(8'h03); send(8'h01);
    reset = 1'b0;
    #1;
    check("mrst_addr", {24'd0, addr_pointer}, 32'h0);
    check("mrst_mode", {24'd0, mode}, 32'h0);
    check("mrst_wdata", {16'd0, wr_data}, 32'h0);
    check_idle_outputs("mrst");
    @(negedge clk);
    reset = 1'b1;
    send(8'hAB); send(8'hCD); send(8'h64);
    repeat (3) @(negedge clk);
    check_idle_outputs("mrst_after");
    check("mrst_count", strobe_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
